regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised 2-read / 1-write CPU register file for the pipelined datapath.
- Adds same-cycle write-to-read bypass, an optional registered-read mode, and a busy-bit scoreboard.
- The scoreboard tracks in-flight destination registers and stalls issue on RAW/WAW hazards.
- Sits between the decode stage (issue, operand read) and the write-back stage.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- READ_REG, 0: 0 = combinational read; 1 = read data registered, 1-cycle latency.
- ZERO_HARD, 1: 1 = register 0 reads as 0 and is never written or marked busy.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous active-high reset.
- rs  in  ADDR_W  read port 1 address.
- rt  in  ADDR_W  read port 2 address.
- ReadData1  out  DATA_W  rs data.
- ReadData2  out  DATA_W  rt data.
- RegWre  in  1  write-back enable.
- WriteReg  in  ADDR_W  write-back address.
- WriteData  in  DATA_W  write-back data.
- IssueValid  in  1  decode requests issue of an instruction reading rs/rt and writing IssueDest.
- IssueDest  in  ADDR_W  destination of the issuing instruction.
- IssueWre  in  1  issuing instruction writes a register.
- Stall  out  1  issue rejected this cycle; decode must hold.
- BusyVec  out  2**ADDR_W  scoreboard snapshot, for debug and verification.

Behaviour:
- Reset
  - Reset is asynchronous and active-high; the clock is CLK and the reset is RST.
  - While RST=1: all registers = 0, BusyVec = 0, registered ReadData1/2 = 0.
  - Stall is combinational; it evaluates to 0 while BusyVec = 0.
  - Reset asserted mid-operation discards all in-flight writes and busy marks immediately.
- Write
  - At posedge, if RegWre && !(ZERO_HARD && WriteReg==0): register[WriteReg] <= WriteData.
- Read, READ_REG=0
  - ReadDataN = 0 if ZERO_HARD and address 0.
  - Else WriteData if RegWre and WriteReg equals the address (write-first bypass).
  - Else register[address].
- Read, READ_REG=1
  - Use the same selection, captured at posedge; output is valid the cycle after the address is presented.
- Scoreboard
  - Effective busy: eb[r] = busy[r] && !(RegWre && WriteReg==r). A same-cycle write-back counts as already cleared.
  - Register 0 is never busy when ZERO_HARD=1.
  - Stall = IssueValid && (eb[rs] || eb[rt] || (IssueWre && eb[IssueDest])). Combinational, no latency.
  - Issue accepted when IssueValid && !Stall.
  - On an accepted issue with IssueWre and IssueDest != 0 (when ZERO_HARD): busy[IssueDest] <= 1 at posedge.
  - RegWre at posedge: busy[WriteReg] <= 0.
  - Same register set and cleared in one cycle: set wins. The new producer owns it; the old value is still written.
  - Write-back to a non-busy register is legal; data is written and busy stays 0.
  - Issue with IssueWre=0 never sets busy.
- Widths
  - No arithmetic; all comparisons are full ADDR_W.
  - Depth is exactly 2**ADDR_W, so there are no out-of-range addresses.

Decomposition:
- Shared package `regfile_pkg`:
  - DATA_W and ADDR_W defaults.
  - ZERO_REG constant (0).
  - A `reg_addr_t` typedef of width ADDR_W.
- One sub-module, `rf_scoreboard`:
  - Holds the busy vector, eb computation, Stall, and set/clear priority.
  - Instanced once; storage and bypass stay in the top.

Test Plan:
- Reset: RST=1 mid-run after writing r5=0xDEADBEEF -> ReadData1(rs=5)=0, BusyVec=0, Stall=0 with IssueValid=1.
- Bypass: RegWre=1, WriteReg=7, WriteData=0x12345678, rs=7, READ_REG=0 -> ReadData1=0x12345678 in the same cycle; next cycle still 0x12345678 with RegWre=0.
- Zero register: write r0=0xFFFFFFFF, then issue with IssueDest=0 -> ReadData1(rs=0)=0, BusyVec[0]=0.
- RAW stall: issue IssueDest=3 accepted. Next cycle issue rs=3 -> Stall=1 until a cycle with RegWre=1, WriteReg=3; in that cycle Stall=0 and ReadData1 = WriteData.
- WAW set-wins: busy[4]=1; same cycle RegWre, WriteReg=4, WriteData=0xA5 plus accepted issue IssueDest=4 -> register[4]=0xA5, BusyVec[4]=1 next cycle.
- READ_REG=1: write r9=0x55, present rs=9 -> ReadData1=0x55 one cycle later, not in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address type for the register file and its scoreboard.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG = 0;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy-bit tracker that stalls issue on RAW/WAW hazards against in-flight writes.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ZERO_HARD = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_W-1:0]    rs,
    input  logic [ADDR_W-1:0]    rt,
    input  logic                 RegWre,
    input  logic [ADDR_W-1:0]    WriteReg,
    input  logic                 IssueValid,
    input  logic [ADDR_W-1:0]    IssueDest,
    input  logic                 IssueWre,
    output logic                 Stall,
    output logic [2**ADDR_W-1:0] BusyVec
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    logic [DEPTH-1:0] busy_q, busy_d, clr, set, eb;
    always_comb begin
        clr = '0;
        if (RegWre) clr[WriteReg] = 1'b1;
        eb = busy_q & ~clr;
        Stall = IssueValid && (eb[rs] || eb[rt] || (IssueWre && eb[IssueDest]));
        set = '0;
        if (IssueValid && !Stall && IssueWre && !(ZERO_HARD != 0 && IssueDest == ZERO_A))
            set[IssueDest] = 1'b1;
        // a new producer claiming the register outranks the retiring write-back
        busy_d = (busy_q & ~clr) | set;
        BusyVec = busy_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) busy_q <= '0;
        else busy_q <= busy_d;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with write-first bypass,
// optional registered read and a busy-bit issue scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int READ_REG = 0,
    parameter int ZERO_HARD = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_W-1:0]    rs,
    input  logic [ADDR_W-1:0]    rt,
    output logic [DATA_W-1:0]    ReadData1,
    output logic [DATA_W-1:0]    ReadData2,
    input  logic                 RegWre,
    input  logic [ADDR_W-1:0]    WriteReg,
    input  logic [DATA_W-1:0]    WriteData,
    input  logic                 IssueValid,
    input  logic [ADDR_W-1:0]    IssueDest,
    input  logic                 IssueWre,
    output logic                 Stall,
    output logic [2**ADDR_W-1:0] BusyVec
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd1_d, rd2_d;
    logic we;
    always_comb begin
        we = RegWre && !(ZERO_HARD != 0 && WriteReg == ZERO_A);
        regs_d = regs_q;
        if (we) regs_d[WriteReg] = WriteData;
        rd1_d = (ZERO_HARD != 0 && rs == ZERO_A) ? '0 :
                (RegWre && WriteReg == rs) ? WriteData : regs_q[rs];
        rd2_d = (ZERO_HARD != 0 && rt == ZERO_A) ? '0 :
                (RegWre && WriteReg == rt) ? WriteData : regs_q[rt];
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd1_q, rd2_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= rd1_d;
                    rd2_q <= rd2_d;
                end
            end
            assign ReadData1 = rd1_q;
            assign ReadData2 = rd2_q;
        end else begin : g_rd_comb
            assign ReadData1 = rd1_d;
            assign ReadData2 = rd2_d;
        end
    endgenerate
    rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_HARD(ZERO_HARD)) u_sb (
        .CLK(CLK),
        .RST(RST),
        .rs(rs),
        .rt(rt),
        .RegWre(RegWre),
        .WriteReg(WriteReg),
        .IssueValid(IssueValid),
        .IssueDest(IssueDest),
        .IssueWre(IssueWre),
        .Stall(Stall),
        .BusyVec(BusyVec)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of a combinational-read and a registered-read
// instance driven by the same stimulus.
module tb_regfile_scoreboard;
    import regfile_pkg::*;
    logic CLK = 0;
    logic RST = 1;
    reg_addr_t rs = '0, rt = '0, WriteReg = '0, IssueDest = '0;
    logic RegWre = 0, IssueValid = 0, IssueWre = 0;
    logic [31:0] WriteData = '0;
    logic [31:0] rd1_c, rd2_c, rd1_r, rd2_r, busy_c, busy_r;
    logic stall_c, stall_r;
    int errors = 0;
    int checks = 0;
    always #5 CLK = ~CLK;
    regfile_scoreboard #(.READ_REG(0)) u_c (
        .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .ReadData1(rd1_c), .ReadData2(rd2_c),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
        .IssueValid(IssueValid), .IssueDest(IssueDest), .IssueWre(IssueWre),
        .Stall(stall_c), .BusyVec(busy_c)
    );
    regfile_scoreboard #(.READ_REG(1)) u_r (
        .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .ReadData1(rd1_r), .ReadData2(rd2_r),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
        .IssueValid(IssueValid), .IssueDest(IssueDest), .IssueWre(IssueWre),
        .Stall(stall_r), .BusyVec(busy_r)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    initial begin
        tick();
        #1;
        chk("rst_rd1", rd1_c, 32'h0);
        chk("rst_rd1_reg", rd1_r, 32'h0);
        chk("rst_busy", busy_c, 32'h0);
        chk("rst_stall", {31'b0, stall_c}, 32'h0);
        tick();
        RST = 0;
        RegWre = 1; WriteReg = 5; WriteData = 32'hDEADBEEF; rs = 5;
        #1;
        chk("wr5_bypass", rd1_c, 32'hDEADBEEF);
        tick();
        RegWre = 0;
        IssueValid = 1; IssueWre = 1; IssueDest = 6; rt = 0;
        #1;
        chk("wr5_stored", rd1_c, 32'hDEADBEEF);
        chk("wr5_reg_rd", rd1_r, 32'hDEADBEEF);
        chk("iss6_nostall", {31'b0, stall_c}, 32'h0);
        tick();
        chk("iss6_busy", busy_c, 32'h0000_0040);
        RST = 1;
        #1;
        chk("midrst_rd1", rd1_c, 32'h0);
        chk("midrst_rd1_reg", rd1_r, 32'h0);
        chk("midrst_busy", busy_c, 32'h0);
        chk("midrst_stall", {31'b0, stall_c}, 32'h0);
        IssueValid = 0; IssueWre = 0;
        tick();
        RST = 0;
        RegWre = 1; WriteReg = 7; WriteData = 32'h12345678; rs = 7; rt = 7;
        #1;
        chk("byp_same", rd1_c, 32'h12345678);
        chk("byp_same_rt", rd2_c, 32'h12345678);
        tick();
        RegWre = 0;
        #1;
        chk("byp_next", rd1_c, 32'h12345678);
        RegWre = 1; WriteReg = 0; WriteData = 32'hFFFFFFFF; rs = 0;
        #1;
        chk("r0_wr_rd", rd1_c, 32'h0);
        tick();
        RegWre = 0;
        IssueValid = 1; IssueWre = 1; IssueDest = 0;
        #1;
        chk("r0_rd", rd1_c, 32'h0);
        chk("r0_iss_stall", {31'b0, stall_c}, 32'h0);
        tick();
        IssueValid = 0;
        chk("r0_busy", busy_c, 32'h0);
        IssueValid = 1; IssueWre = 1; IssueDest = 3; rs = 1; rt = 2;
        #1;
        chk("raw_iss3", {31'b0, stall_c}, 32'h0);
        tick();
        chk("raw_busy3", busy_c, 32'h0000_0008);
        IssueDest = 10; rs = 3; rt = 0;
        #1;
        chk("raw_stall1", {31'b0, stall_c}, 32'h1);
        tick();
        chk("raw_stall2", {31'b0, stall_c}, 32'h1);
        chk("raw_held", busy_c, 32'h0000_0008);
        RegWre = 1; WriteReg = 3; WriteData = 32'hCAFEF00D;
        #1;
        chk("raw_wb_nostall", {31'b0, stall_c}, 32'h0);
        chk("raw_wb_data", rd1_c, 32'hCAFEF00D);
        tick();
        RegWre = 0;
        chk("raw_busy10", busy_c, 32'h0000_0400);
        rs = 0; rt = 0; IssueDest = 10;
        #1;
        chk("waw_stall", {31'b0, stall_c}, 32'h1);
        IssueWre = 0;
        #1;
        chk("nowr_nostall", {31'b0, stall_c}, 32'h0);
        rt = 10;
        #1;
        chk("rt_stall", {31'b0, stall_c}, 32'h1);
        rt = 0;
        tick();
        chk("nowr_nobusy", busy_c, 32'h0000_0400);
        IssueWre = 1; IssueDest = 4;
        tick();
        chk("busy4", busy_c, 32'h0000_0410);
        RegWre = 1; WriteReg = 4; WriteData = 32'h000000A5;
        #1;
        chk("setwin_nostall", {31'b0, stall_c}, 32'h0);
        tick();
        RegWre = 0; IssueValid = 0; IssueWre = 0; rs = 4;
        #1;
        chk("setwin_data", rd1_c, 32'h000000A5);
        chk("setwin_busy", busy_c, 32'h0000_0410);
        RegWre = 1; WriteReg = 8; WriteData = 32'h00000077;
        tick();
        RegWre = 0; rs = 8;
        #1;
        chk("nonbusy_wb_busy", busy_c, 32'h0000_0410);
        chk("nonbusy_wb_data", rd1_c, 32'h00000077);
        tick();
        chk("regrd_8", rd1_r, 32'h00000077);
        RegWre = 1; WriteReg = 9; WriteData = 32'h00000055; rs = 9;
        #1;
        chk("regrd_same_cyc", rd1_r, 32'h00000077);
        chk("comb_same_cyc", rd1_c, 32'h00000055);
        tick();
        RegWre = 0;
        #1;
        chk("regrd_next_cyc", rd1_r, 32'h00000055);
        chk("regrd_busy", busy_r, 32'h0000_0410);
        chk("regrd_stall", {31'b0, stall_r}, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
